// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter pixel-write port between food, snake and a full-screen clear sweep.
// Optional: define PLOT_ARB_CLIP_EN to drop (but still consume) off-screen request pixels.
module vga_plot_arbiter #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COL_W    = 3,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_req,
    input  logic [COL_W-1:0] clear_colour,
    output logic             clear_busy,
    input  logic             req0,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [COL_W-1:0] col0,
    input  logic             req1,
    input  logic [X_W-1:0]   x1,
    input  logic [Y_W-1:0]   y1,
    input  logic [COL_W-1:0] col1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [X_W-1:0]   plot_x,
    output logic [Y_W-1:0]   plot_y,
    output logic [COL_W-1:0] plot_colour,
    output logic             plot
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [X_W-1:0]   cx_q, cx_d;
    logic [Y_W-1:0]   cy_q, cy_d;
    logic [COL_W-1:0] colour_q, colour_d;
    logic             plot_d;
    logic [X_W-1:0]   plot_x_d;
    logic [Y_W-1:0]   plot_y_d;
    logic [COL_W-1:0] plot_colour_d;

    // Pixel chosen by the arbiter this cycle
    logic             xfer;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [COL_W-1:0] sel_col;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB;
            last_q      <= 1'b1;
            cx_q        <= '0;
            cy_q        <= '0;
            colour_q    <= '0;
            plot        <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            colour_q    <= colour_d;
            plot        <= plot_d;
            plot_x      <= plot_x_d;
            plot_y      <= plot_y_d;
            plot_colour <= plot_colour_d;
        end
    end

    // Next state, grants and next pixel
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        colour_d      = colour_q;
        plot_d        = 1'b0;
        plot_x_d      = plot_x;
        plot_y_d      = plot_y;
        plot_colour_d = plot_colour;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        xfer          = 1'b0;
        sel_x         = x0;
        sel_y         = y0;
        sel_col       = col0;

        case (state_q)
            ARB: begin
                if (clear_req) begin
                    colour_d = clear_colour;
                    cx_d     = '0;
                    cy_d     = '0;
                    state_d  = CLEAR;
                end else if (req0 && (!req1 || last_q)) begin
                    gnt0   = 1'b1;
                    xfer   = 1'b1;
                    last_d = 1'b0;
                end else if (req1) begin
                    gnt1    = 1'b1;
                    xfer    = 1'b1;
                    last_d  = 1'b1;
                    sel_x   = x1;
                    sel_y   = y1;
                    sel_col = col1;
                end

                if (xfer) begin
`ifdef PLOT_ARB_CLIP_EN
                    if ((sel_x <= X_LAST) && (sel_y <= Y_LAST)) begin
                        plot_d        = 1'b1;
                        plot_x_d      = sel_x;
                        plot_y_d      = sel_y;
                        plot_colour_d = sel_col;
                    end
`else
                    plot_d        = 1'b1;
                    plot_x_d      = sel_x;
                    plot_y_d      = sel_y;
                    plot_colour_d = sel_col;
`endif
                end
            end

            CLEAR: begin
                plot_d        = 1'b1;
                plot_x_d      = cx_q;
                plot_y_d      = cy_q;
                plot_colour_d = colour_q;
                // Raster walk; terminal compares keep cx/cy from overflowing
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        cy_d    = '0;
                        state_d = ARB;
                    end else begin
                        cy_d = cy_q + Y_W'(1);
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                end
            end

            default: state_d = ARB;
        endcase

        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign clear_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed self-checking bench for vga_plot_arbiter: grants, round-robin, clear sweep, reset abort, clipping.
module tb_vga_plot_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_req;
    logic [2:0] clear_colour;
    logic       clear_busy;
    logic       req0, req1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] col0, col1;
    logic       gnt0, gnt1;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_plot_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .req0         (req0),
        .x0           (x0),
        .y0           (y0),
        .col0         (col0),
        .req1         (req1),
        .x1           (x1),
        .y1           (y1),
        .col1         (col1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .plot_x       (plot_x),
        .plot_y       (plot_y),
        .plot_colour  (plot_colour),
        .plot         (plot)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int  npix, busy_cnt, gnt_bad;
    bit  done;
    logic [1:0] exp_g;

    initial begin
        reset = 1'b1; clear_req = 1'b0; clear_colour = 3'd0;
        req0 = 1'b1; x0 = 8'd0; y0 = 7'd0; col0 = 3'd0;
        req1 = 1'b1; x1 = 8'd0; y1 = 7'd0; col1 = 3'd0;
        #1;
        check("gnt0_in_reset", 32'(gnt0), 32'd0);
        check("gnt1_in_reset", 32'(gnt1), 32'd0);
        repeat (3) next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b0;

        // Idle after reset
        repeat (10) next_cycle();
        check("idle_plot", 32'(plot), 32'd0);
        check("idle_busy", 32'(clear_busy), 32'd0);
        check("idle_xyc", {17'd0, plot_x, plot_y}, 32'd0);
        check("idle_col", 32'(plot_colour), 32'd0);
        check("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);

        // Single food request
        req0 = 1'b1; x0 = 8'd80; y0 = 7'd60; col0 = 3'b100;
        #1;
        check("single_gnt0", 32'(gnt0), 32'd1);
        check("single_gnt1", 32'(gnt1), 32'd0);
        next_cycle();
        req0 = 1'b0;
        check("single_plot", 32'(plot), 32'd1);
        check("single_x", 32'(plot_x), 32'd80);
        check("single_y", 32'(plot_y), 32'd60);
        check("single_col", 32'(plot_colour), 32'd4);
        next_cycle();
        check("single_plot_off", 32'(plot), 32'd0);

        // Fresh reset so the round-robin pointer starts at its reset value
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        req0 = 1'b1; x0 = 8'd10; y0 = 7'd1; col0 = 3'd1;
        req1 = 1'b1; x1 = 8'd20; y1 = 7'd2; col1 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            check("rr_gnt", {30'd0, gnt1, gnt0}, 32'(exp_g));
            next_cycle();
            check("rr_plot", 32'(plot), 32'd1);
            check("rr_x", 32'(plot_x), (i % 2 == 0) ? 32'd10 : 32'd20);
        end
        req0 = 1'b0;
        #1;
        check("rr_gnt1_alone", 32'(gnt1), 32'd1);

        // Clear sweep with snake request pending
        clear_req = 1'b1; clear_colour = 3'b000;
        #1;
        check("clr_accept_gnt1", 32'(gnt1), 32'd0);
        npix = 0; busy_cnt = 0; gnt_bad = 0; done = 1'b0;
        for (int c = 0; c < 19300 && !done; c++) begin
            next_cycle();
            if (c == 0) begin
                clear_req = 1'b0;
                check("clr_first_busy", 32'(clear_busy), 32'd1);
                check("clr_first_x", 32'(plot_x), 32'd20);
            end
            if (plot && (c > 0)) begin
                if (npix == 0)
                    check("clr_pix0", {17'd0, plot_x, plot_y}, {17'd0, 8'd0, 7'd0});
                if (npix == 1)
                    check("clr_pix1", {17'd0, plot_x, plot_y}, {17'd0, 8'd1, 7'd0});
                if (npix == 160)
                    check("clr_pix160", {17'd0, plot_x, plot_y}, {17'd0, 8'd0, 7'd1});
                if (npix == 19199) begin
                    check("clr_last", {17'd0, plot_x, plot_y}, {17'd0, 8'd159, 7'd119});
                    check("clr_last_col", 32'(plot_colour), 32'd0);
                end
                npix++;
            end
            if (clear_busy) busy_cnt++;
            #1;
            if (npix == 19200) begin
                check("clr_gnt1_after", 32'(gnt1), 32'd1);
                done = 1'b1;
            end else if (gnt1) begin
                gnt_bad++;
            end
        end
        check("clr_done", 32'(done), 32'd1);
        check("clr_npix", 32'(npix), 32'd19200);
        check("clr_busy_cycles", 32'(busy_cnt), 32'd19200);
        check("clr_gnt1_leak", 32'(gnt_bad), 32'd0);
        next_cycle();
        req1 = 1'b0;
        check("post_clr_plot", 32'(plot), 32'd1);
        check("post_clr_x", 32'(plot_x), 32'd20);
        check("post_clr_y", 32'(plot_y), 32'd2);

        // Reset aborts a sweep part-way
        clear_req = 1'b1; clear_colour = 3'b011;
        next_cycle();
        clear_req = 1'b0;
        npix = 0;
        for (int c = 0; c < 600 && npix < 500; c++) begin
            next_cycle();
            if (plot) npix++;
        end
        check("abort_npix", 32'(npix), 32'd500);
        check("abort_col", 32'(plot_colour), 32'd3);
        reset = 1'b1;
        next_cycle();
        check("abort_busy", 32'(clear_busy), 32'd0);
        check("abort_plot", 32'(plot), 32'd0);
        reset = 1'b0;
        req0 = 1'b1; x0 = 8'd33; y0 = 7'd44; col0 = 3'd5;
        #1;
        check("abort_gnt0", 32'(gnt0), 32'd1);
        next_cycle();
        req0 = 1'b0;
        check("abort_req_plot", 32'(plot), 32'd1);
        check("abort_req_x", 32'(plot_x), 32'd33);

        // Off-screen request
        req1 = 1'b1; x1 = 8'd160; y1 = 7'd10; col1 = 3'd6;
        #1;
        check("clip_gnt1", 32'(gnt1), 32'd1);
        next_cycle();
        req1 = 1'b0;
`ifdef PLOT_ARB_CLIP_EN
        check("clip_plot", 32'(plot), 32'd0);
        check("clip_x_hold", 32'(plot_x), 32'd33);
        check("clip_col_hold", 32'(plot_colour), 32'd5);
`else
        check("noclip_plot", 32'(plot), 32'd1);
        check("noclip_x", 32'(plot_x), 32'd160);
        check("noclip_y", 32'(plot_y), 32'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
